// File: rtl/cdi_slave_pkg.sv
// rtl/cdi_slave_pkg.sv - shared types and constants for the CDi slave bus bridge
package cdi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_IRQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ACK   = 3'd4,
    ST_ERR   = 3'd5,
    ST_HOLD  = 3'd6
  } slave_bridge_state_t;

  localparam logic [15:0] SLAVE_TIMEOUT_DATA = 16'hFFFF;

endpackage

// File: rtl/sync_rise_detect.sv
// rtl/sync_rise_detect.sv - 2-flop synchroniser with registered rising-edge pulse
module sync_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [1:0] sync_q;
  logic       prev_q;

  // All-ones reset keeps a line that idles high from looking like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      prev_q <= sync_q[1];
      rise   <= sync_q[1] & ~prev_q;
    end
  end

endmodule

// File: rtl/slave_bus_bridge.sv
// rtl/slave_bus_bridge.sv - host-to-68HC05 slave window handshake bridge
module slave_bus_bridge
  import cdi_slave_pkg::*;
#(
  parameter int IRQ_DELAY = 19,
  parameter int TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        uds,
  input  logic        lds,
  input  logic        write_strobe,
  input  logic [1:0]  addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        bus_ack,
  output logic        bus_err,
  output logic [7:0]  slv_data,
  output logic [1:0]  slv_addr,
  output logic        slv_wr_n,
  output logic        slv_irq_n,
  input  logic [7:0]  slv_rdata,
  input  logic        slv_dtack_n
);

  localparam int CW = $clog2(TIMEOUT + 1);

  slave_bridge_state_t state, next_state;
  logic [CW-1:0] dly_cnt;
  logic [CW-1:0] tmo_cnt;
  logic [CW-1:0] tmo_inc;
  logic          ack_evt;
  logic          start;
  logic          timeout_hit;

  sync_rise_detect u_dtack_sync (
    .clk   (clk),
    .reset (reset),
    .din   (slv_dtack_n),
    .rise  (ack_evt)
  );

  assign start       = cs && (uds || lds);
  assign tmo_inc     = tmo_cnt + CW'(1);
  assign timeout_hit = (tmo_inc == CW'(TIMEOUT));

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_DELAY;
      ST_DELAY: begin
        if (!cs)                next_state = ST_IDLE;
        else if (ack_evt)       next_state = ST_ACK;
        else if (timeout_hit)   next_state = ST_ERR;
        else if (dly_cnt == '0) next_state = ST_IRQ;
      end
      ST_IRQ: begin
        if (!cs)              next_state = ST_IDLE;
        else if (ack_evt)     next_state = ST_ACK;
        else if (timeout_hit) next_state = ST_ERR;
        else                  next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (!cs)              next_state = ST_IDLE;
        else if (ack_evt)     next_state = ST_ACK;
        else if (timeout_hit) next_state = ST_ERR;
      end
      ST_ACK:  next_state = ST_HOLD;
      ST_ERR:  next_state = ST_HOLD;
      ST_HOLD: if (!cs) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      dly_cnt   <= '0;
      tmo_cnt   <= '0;
      bus_ack   <= 1'b0;
      bus_err   <= 1'b0;
      slv_irq_n <= 1'b1;
      slv_wr_n  <= 1'b1;
      slv_data  <= 8'hFF;
      slv_addr  <= 2'b00;
      dout      <= 16'h0000;
    end else begin
      state   <= next_state;
      bus_ack <= (next_state == ST_ACK);
      bus_err <= (next_state == ST_ERR);
      // The pulse fires only if the transaction survives the IRQ cycle.
      slv_irq_n <= !((state == ST_IRQ) && (next_state == ST_WAIT));

      if ((state == ST_IDLE) && start) begin
        slv_addr <= addr;
        slv_wr_n <= !write_strobe;
        slv_data <= (uds && !lds) ? din[15:8] : din[7:0];
        dly_cnt  <= CW'(IRQ_DELAY - 1);
        tmo_cnt  <= '0;
      end else if ((state == ST_DELAY) || (state == ST_IRQ) || (state == ST_WAIT)) begin
        tmo_cnt <= tmo_inc;
        if ((state == ST_DELAY) && (dly_cnt != '0))
          dly_cnt <= dly_cnt - CW'(1);
      end else begin
        dly_cnt <= '0;
        tmo_cnt <= '0;
      end

      if (next_state == ST_ACK)
        dout <= {slv_rdata, slv_rdata};
      else if (next_state == ST_ERR)
        dout <= SLAVE_TIMEOUT_DATA;
    end
  end

endmodule

// File: tb/tb_slave_bus_bridge.sv
// tb/tb_slave_bus_bridge.sv - directed self-checking bench for slave_bus_bridge
module tb_slave_bus_bridge;

  logic        clk = 1'b0;
  logic        reset, cs, uds, lds, write_strobe;
  logic [1:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        bus_ack, bus_err;
  logic [7:0]  slv_data;
  logic [1:0]  slv_addr;
  logic        slv_wr_n, slv_irq_n;
  logic [7:0]  slv_rdata;
  logic        slv_dtack_n;

  int checks = 0;
  int failures = 0;

  int irq_first, irq_cnt, ack_first, ack_cnt, err_first, err_cnt;
  logic [15:0] dout_evt;
  logic [7:0]  data0;
  logic [1:0]  addr0;
  logic        wr0;

  slave_bus_bridge dut (
    .clk         (clk),
    .reset       (reset),
    .cs          (cs),
    .uds         (uds),
    .lds         (lds),
    .write_strobe(write_strobe),
    .addr        (addr),
    .din         (din),
    .dout        (dout),
    .bus_ack     (bus_ack),
    .bus_err     (bus_err),
    .slv_data    (slv_data),
    .slv_addr    (slv_addr),
    .slv_wr_n    (slv_wr_n),
    .slv_irq_n   (slv_irq_n),
    .slv_rdata   (slv_rdata),
    .slv_dtack_n (slv_dtack_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int c);
    if (!slv_irq_n) begin
      if (irq_cnt == 0) irq_first = c;
      irq_cnt++;
    end
    if (bus_ack) begin
      if (ack_cnt == 0) ack_first = c;
      ack_cnt++;
      dout_evt = dout;
    end
    if (bus_err) begin
      if (err_cnt == 0) err_first = c;
      err_cnt++;
      dout_evt = dout;
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_ack"},   32'(bus_ack),   32'd0);
    check({pfx, "_err"},   32'(bus_err),   32'd0);
    check({pfx, "_irq_n"}, 32'(slv_irq_n), 32'd1);
    check({pfx, "_wr_n"},  32'(slv_wr_n),  32'd1);
    check({pfx, "_data"},  32'(slv_data),  32'hFF);
    check({pfx, "_addr"},  32'(slv_addr),  32'd0);
    check({pfx, "_dout"},  32'(dout),      32'd0);
  endtask

  // Start cycle is edge 0; rise_at/drop_at name the edge that first sees the change.
  task automatic run_txn(input logic we, input logic u, input logic l,
                         input logic [1:0] a, input logic [15:0] d, input logic [7:0] rd,
                         input int rise_at, input int drop_at, input int ncyc);
    irq_first = -1; irq_cnt = 0; ack_first = -1; ack_cnt = 0;
    err_first = -1; err_cnt = 0; dout_evt = 16'h0;
    write_strobe = we; uds = u; lds = l; addr = a; din = d;
    slv_rdata = rd; slv_dtack_n = 1'b0; cs = 1'b1;
    step();
    data0 = slv_data; addr0 = slv_addr; wr0 = slv_wr_n;
    sample(0);
    for (int c = 1; c <= ncyc; c++) begin
      if (c == rise_at) slv_dtack_n = 1'b1;
      if (c == drop_at) cs = 1'b0;
      step();
      sample(c);
    end
    cs = 1'b0; uds = 1'b0; lds = 1'b0;
    step();
    step();
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; uds = 1'b0; lds = 1'b0; write_strobe = 1'b0;
    addr = 2'b00; din = 16'h0; slv_rdata = 8'h00; slv_dtack_n = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_reset_values("rst");

    run_txn(1'b0, 1'b1, 1'b1, 2'b01, 16'h0000, 8'hA5, 60, -1, 80);
    check("rd_addr",      32'(addr0),     32'd1);
    check("rd_wr_n",      32'(wr0),       32'd1);
    check("rd_irq_cycle", 32'(irq_first), 32'd20);
    check("rd_irq_cnt",   32'(irq_cnt),   32'd1);
    check("rd_ack_cycle", 32'(ack_first), 32'd63);
    check("rd_ack_cnt",   32'(ack_cnt),   32'd1);
    check("rd_dout",      32'(dout_evt),  32'hA5A5);
    check("rd_err_cnt",   32'(err_cnt),   32'd0);

    run_txn(1'b1, 1'b1, 1'b0, 2'b10, 16'h3C00, 8'h00, 30, -1, 50);
    check("wu_data",      32'(data0),     32'h3C);
    check("wu_wr_n",      32'(wr0),       32'd0);
    check("wu_addr",      32'(addr0),     32'd2);
    check("wu_ack_cycle", 32'(ack_first), 32'd33);
    check("wu_ack_cnt",   32'(ack_cnt),   32'd1);

    run_txn(1'b1, 1'b0, 1'b1, 2'b11, 16'h0012, 8'h00, 30, -1, 50);
    check("wl_data",    32'(data0),   32'h12);
    check("wl_ack_cnt", 32'(ack_cnt), 32'd1);

    run_txn(1'b0, 1'b1, 1'b1, 2'b00, 16'h0000, 8'h5A, 5, -1, 40);
    check("early_irq_cnt",   32'(irq_cnt),   32'd0);
    check("early_ack_cycle", 32'(ack_first), 32'd8);
    check("early_dout",      32'(dout_evt),  32'h5A5A);

    run_txn(1'b0, 1'b1, 1'b1, 2'b00, 16'h0000, 8'h77, 40, 30, 60);
    check("abort_irq_cnt", 32'(irq_cnt), 32'd1);
    check("abort_ack_cnt", 32'(ack_cnt), 32'd0);
    check("abort_err_cnt", 32'(err_cnt), 32'd0);
    check("abort_dout",    32'(dout),    32'h5A5A);

    run_txn(1'b0, 1'b1, 1'b1, 2'b00, 16'h0000, 8'h00, -1, -1, 4100);
    check("tmo_err_cycle", 32'(err_first), 32'd4096);
    check("tmo_err_cnt",   32'(err_cnt),   32'd1);
    check("tmo_ack_cnt",   32'(ack_cnt),   32'd0);
    check("tmo_dout",      32'(dout_evt),  32'hFFFF);
    check("tmo_dout_hold", 32'(dout),      32'hFFFF);

    run_txn(1'b0, 1'b1, 1'b1, 2'b10, 16'h0000, 8'h3C, 25, -1, 40);
    check("post_ack_cycle", 32'(ack_first), 32'd28);
    check("post_dout",      32'(dout_evt),  32'h3C3C);

    write_strobe = 1'b1; uds = 1'b1; lds = 1'b0; addr = 2'b11; din = 16'hC300;
    slv_dtack_n = 1'b0; cs = 1'b1;
    step();
    check("mid_data", 32'(slv_data), 32'hC3);
    for (int c = 1; c <= 4; c++) step();
    reset = 1'b1;
    step();
    check_reset_values("mid");
    reset = 1'b0; cs = 1'b0; uds = 1'b0;
    step();
    check("mid_idle_ack", 32'(bus_ack), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
